progloader: RTL and testbench
=============================

# progloader

Program loader: writer side of the program memory. Receives a byte stream over a valid/ready handshake, assembles 16-bit instruction words (high byte first), and writes them sequentially from address 0 into the writable program memory port. Holds the processor off (`busy`) while loading. Sits between the I/O byte receiver and the program memory write port.

## Interface

Parameters:
- `AW`, 10, program memory address width
- `DW`, 16, instruction word width (fixed at 2 bytes)
- `MAXWORDS`, 1024, largest legal load length

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a load session (sampled in IDLE, DONE-return, ERR only)
- `rx_data`  in  8  incoming byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  loader accepts byte this cycle
- `we`  out  1  program memory write enable
- `wa`  out  AW  program memory write address
- `wd`  out  DW  program memory write data
- `busy`  out  1  load in progress; processor/PC held in reset
- `done`  out  1  one-cycle pulse: load completed
- `err`  out  1  sticky: illegal length header

## Operation

- Stream format: LEN_HI, LEN_LO (word count N, 16-bit), then N × (WORD_HI, WORD_LO).
- Byte accepted on a rising edge where `rx_valid && rx_ready`.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR.
- IDLE: `rx_ready`=0, `busy`=0. `start` → LEN_HI; clears `err`, address counter to 0, word counter to 0.
- LEN_HI: `rx_ready`=1; accept → len[15:8], go LEN_LO.
- LEN_LO: `rx_ready`=1; accept → len[7:0]. If N==0 or N>MAXWORDS → ERR, else DATA_HI.
- DATA_HI: `rx_ready`=1; accept → hi byte register, go DATA_LO.
- DATA_LO: `rx_ready`=1; accept → `wd`={hi,lo}, go WRITE.
- WRITE: `rx_ready`=0, `we`=1 for exactly one cycle, `wa`=address counter. At end of cycle: address+1, count+1; if count+1==N → DONE else DATA_HI.
- DONE: `done`=1 one cycle, `busy`=0, → IDLE.
- ERR: `err`=1 (sticky), `busy`=0, `rx_ready`=0; `start` → LEN_HI (clears `err`).
- `busy`=1 in LEN_HI through WRITE inclusive.
- `start` while busy: ignored. `rx_valid` while `rx_ready`=0: byte not consumed (source holds it).
- Address counter is AW bits; N≤MAXWORDS guarantees no wrap within a session.

## Timing

- All outputs registered / decoded from state register; no combinational path input→output except none.
- Reset values: `rx_ready`=0, `we`=0, `wa`=0, `wd`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- Memory samples `we/wa/wd` at the rising edge ending the WRITE cycle.
- Minimum cycles per word with `rx_valid` held high: 3 (DATA_HI, DATA_LO, WRITE). Full load of N words: 1 (start) + 2 + 3N + 1 (DONE).
- `wd` stable from WRITE entry until next DATA_LO accept.
- Reset mid-load: immediate return to reset values; memory contents written so far retained, remainder undefined; next session restarts at address 0.

## Structure

- Shared package: state enumeration, `AW`, `DW`, `MAXWORDS`, byte width constant.
- Single FSM module with address/word counters and hi-byte register; no sub-module. Writable program memory is a separate block.

## Test plan

- Load N=3: bytes 00 03, 12 34, AB CD, FF 00 → writes 0x1234@0, 0xABCD@1, 0xFF00@2; `done` pulses once; `busy` falls with `done`.
- `rx_valid` gaps of random 0–5 cycles between bytes → identical memory image, no extra `we` pulses.
- Length 0x0000 and 0x0401 → ERR, `err`=1, no `we`; subsequent `start` with N=1 clears `err` and writes at 0.
- Reset asserted after word 1 of N=4 → all outputs 0 next edge; new session N=2 writes addresses 0 and 1.
- N=1024 all words = address value → last write `wa`=1023, `wd`=0x03FF, then `done`.
- `start` pulsed during DATA_HI → ignored; `rx_valid` high in IDLE → `rx_ready` stays 0.

Source files
------------

// File: rtl/progloader_pkg.sv
// Shared constants and state encoding for the program loader.
package progloader_pkg;
  localparam int PL_AW       = 10;
  localparam int PL_DW       = 16;
  localparam int PL_MAXWORDS = 1024;
  localparam int BYTE_W      = 8;
  localparam int LEN_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_WRITE   = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_e;
endpackage

// File: rtl/progloader.sv
// Program loader: turns a length-prefixed byte stream into sequential
// 16-bit program memory writes starting at address 0.
module progloader
  import progloader_pkg::*;
#(
  parameter int AW       = PL_AW,
  parameter int DW       = PL_DW,
  parameter int MAXWORDS = PL_MAXWORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              we,
  output logic [AW-1:0]     wa,
  output logic [DW-1:0]     wd,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [DW-1:0]     wd_q, wd_d;
  logic [LEN_W-1:0]  len_full;
  logic              acc;

  // Outputs decode straight from the state register, so none depend on inputs.
  assign rx_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
  assign busy     = rx_ready || (state_q == S_WRITE);
  assign we       = (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign wa       = addr_q;
  assign wd       = wd_q;

  assign acc      = rx_valid && rx_ready;
  assign len_full = {len_q[LEN_W-1:BYTE_W], rx_data};

  // State, counters and data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // DONE falls back to IDLE unless a new session is requested right away.
        if (state_q == S_DONE) state_d = S_IDLE;
        if (start) begin
          state_d = S_LEN_HI;
          addr_d  = '0;
          cnt_d   = '0;
        end
      end
      S_LEN_HI: if (acc) begin
        len_d[LEN_W-1:BYTE_W] = rx_data;
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (acc) begin
        len_d = len_full;
        if (len_full == '0 || 32'(len_full) > 32'(MAXWORDS)) state_d = S_ERR;
        else                                                 state_d = S_DATA_HI;
      end
      S_DATA_HI: if (acc) begin
        hi_d    = rx_data;
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (acc) begin
        wd_d    = DW'({hi_q, rx_data});
        state_d = S_WRITE;
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q + 1'b1 == len_q) state_d = S_DONE;
        else                       state_d = S_DATA_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_progloader.sv
// Randomized scoreboard bench for progloader.
module tb_progloader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, we, busy, done, err;
  logic [9:0]  wa;
  logic [15:0] wd;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int exp_addr = 0;
  logic [25:0] exp_q[$];
  logic [15:0] fixed_w[3] = '{16'h1234, 16'hABCD, 16'hFF00};

  always #5 clk = ~clk;

  progloader dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .we(we), .wa(wa), .wd(wd),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every write must match the oldest expected (address, word).
  always @(negedge clk) begin
    if (!reset && we) begin
      if (exp_q.size() == 0) check("extra_we", {22'd0, wa}, 32'hFFFF_FFFF);
      else begin
        logic [25:0] e;
        e = exp_q.pop_front();
        check("write", {6'd0, wa, wd}, {6'd0, e});
        check("ready_in_write", {31'd0, rx_ready}, 32'd0);
      end
    end
    if (!reset && done) begin
      done_cnt++;
      check("busy_with_done", {31'd0, busy}, 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      if (rx_ready) break;
      @(negedge clk);
    end
    if (k == 50) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // wsel: 0 random words, 1 word==address, 2 fixed table.
  task automatic session(input int n, input int gap_max, input int wsel, input bit poke);
    int d0, k;
    logic [15:0] w, nn;
    bit bad;
    nn  = 16'(n);
    bad = (n == 0) || (n > 1024);
    d0  = done_cnt;
    exp_addr = 0;
    pulse_start();
    check("err_cleared", {31'd0, err}, 32'd0);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    send_byte(nn[15:8], $urandom_range(gap_max));
    send_byte(nn[7:0], $urandom_range(gap_max));
    if (bad) begin
      for (k = 0; k < 10 && !err; k++) @(negedge clk);
      check("err_set", {31'd0, err}, 32'd1);
      check("err_busy", {31'd0, busy}, 32'd0);
      check("err_ready", {31'd0, rx_ready}, 32'd0);
      repeat (3) @(negedge clk);
      check("err_sticky", {31'd0, err}, 32'd1);
      check("err_no_write", exp_q.size(), 32'd0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      case (wsel)
        1:       w = 16'(i);
        2:       w = fixed_w[i % 3];
        default: w = 16'($urandom);
      endcase
      send_byte(w[15:8], $urandom_range(gap_max));
      if (poke && i == 0) begin
        pulse_start();
        check("start_ignored_busy", {31'd0, busy}, 32'd1);
      end
      exp_q.push_back({10'(exp_addr), w});
      exp_addr++;
      send_byte(w[7:0], $urandom_range(gap_max));
    end
    for (k = 0; k < 20 && busy; k++) @(negedge clk);
    check("busy_fall_timeout", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    check("done_once", done_cnt - d0, 32'd1);
    check("all_writes_seen", exp_q.size(), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    check("rst_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_wa", {22'd0, wa}, 32'd0);
    check("rst_wd", {16'd0, wd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // IDLE ignores rx_valid.
    rx_valid = 1'b1;
    rx_data = 8'h55;
    repeat (4) begin
      @(negedge clk);
      check("idle_ready", {31'd0, rx_ready}, 32'd0);
    end
    rx_valid = 1'b0;

    session(3, 0, 2, 1'b0);
    session(3, 5, 2, 1'b0);
    session(0, 2, 0, 1'b0);
    session(1, 0, 0, 1'b0);
    session(16'h0401, 2, 0, 1'b0);
    session(1, 3, 0, 1'b0);
    session(5, 3, 0, 1'b1);
    for (int s = 0; s < 6; s++) session($urandom_range(1, 12), 5, 0, 1'b0);

    // Reset in the middle of a 4-word load.
    exp_addr = 0;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    exp_q.push_back({10'd0, 16'hBEEF});
    send_byte(8'hBE, 1);
    send_byte(8'hEF, 1);
    repeat (2) @(negedge clk);
    send_byte(8'h77, 0);
    reset = 1'b1;
    #1;
    check("midrst_outputs", {busy, rx_ready, we, done, err, 11'd0, wd[15:0]},
          32'd0);
    check("midrst_wa", {22'd0, wa}, 32'd0);
    check("midrst_queue", exp_q.size(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    session(2, 2, 0, 1'b0);

    // Maximum length, word value equals its address.
    session(1024, 0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
